tl_monitor: RTL

- Passive observer on the traffic-light controller's output interface: consumes the encoded lamp codes La/Lb plus the street sensors Ta/Tb, and decodes them into one-hot lamp drives.
- Tracks the light phase and checks every transition against the controller's transition rules.
- Reports errors, completed rounds and green-phase starvation.
- Sits beside the controller in the intersection top level and in the verification harness as the receiving end of the La/Lb interface.

---
 rtl/tl_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tl_monitor.sv
// Passive checker on the traffic-light controller's La/Lb interface. It decodes
// the lamp codes, tracks the phase and flags illegal codes or transitions.
module tl_monitor #(
    parameter int CNT_W     = 8,
    parameter int MAX_GREEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             Ta,
    input  logic             Tb,
    output logic [2:0]       lamp_a,
    output logic [2:0]       lamp_b,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] rounds,
    output logic             starve
);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    localparam logic [1:0] P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3;
    localparam logic [1:0] E_NONE = 2'b00, E_ENC = 2'b01, E_TRANS = 2'b10, E_SENS = 2'b11;
    localparam logic [7:0] MAX_G = 8'(MAX_GREEN);

    state_t           state_q, state_d;
    logic [1:0]       prev_pat_q, prev_pat_d;
    logic             prev_ta_q, prev_ta_d, prev_tb_q, prev_tb_d;
    logic [7:0]       dwell_q, dwell_d;
    logic [2:0]       lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
    logic [1:0]       phase_q, phase_d;
    logic             err_q, err_d, starve_q, starve_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, rounds_q, rounds_d;

    logic       legal, in_pair, is_err, green, is_locked;
    logic [1:0] pat, exp_pat, ecode;

    function automatic logic [2:0] decode(input logic [1:0] c);
        case (c)
            2'b00:   decode = 3'b001;
            2'b01:   decode = 3'b010;
            2'b11:   decode = 3'b100;
            default: decode = 3'b000;
        endcase
    endfunction

    always_comb begin
        legal = 1'b1;
        pat   = P0;
        case ({La, Lb})
            4'b0011: pat = P0;
            4'b0111: pat = P1;
            4'b1100: pat = P2;
            4'b1101: pat = P3;
            default: legal = 1'b0;
        endcase

        case (prev_pat_q)
            P0:      exp_pat = prev_ta_q ? P0 : P1;
            P1:      exp_pat = P2;
            P2:      exp_pat = prev_tb_q ? P2 : P3;
            default: exp_pat = P0;
        endcase

        // P0/P1 share bit1=0 and P2/P3 bit1=1, so the sensor-dependent pair is a bit test
        in_pair   = (prev_pat_q == P0 && !pat[1]) || (prev_pat_q == P2 && pat[1]);
        is_locked = (state_q == LOCKED);

        ecode = E_NONE;
        if (!legal)
            ecode = E_ENC;
        else if (is_locked && pat != exp_pat)
            ecode = in_pair ? E_SENS : E_TRANS;
        is_err = (ecode != E_NONE);

        state_d = state_q;
        if (is_locked)
            state_d = is_err ? UNLOCKED : LOCKED;
        else if (legal && pat == P0)
            state_d = LOCKED;

        green = legal && !pat[0];
        if (is_locked && green && pat == prev_pat_q)
            dwell_d = (dwell_q >= MAX_G) ? MAX_G : dwell_q + 8'd1;
        else if (green)
            dwell_d = 8'd1;
        else
            dwell_d = 8'd0;

        starve_d = is_locked && !is_err && dwell_d >= MAX_G &&
                   ((pat == P0 && Tb) || (pat == P2 && Ta));

        rounds_d = rounds_q;
        if (is_locked && !is_err && pat == P0 && prev_pat_q == P3)
            rounds_d = rounds_q + 1'b1;

        err_d      = err_q | is_err;
        err_code_d = (is_err && err_code_q == E_NONE) ? ecode : err_code_q;
        err_cnt_d  = (is_err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;

        phase_d    = legal ? pat : phase_q;
        prev_pat_d = legal ? pat : prev_pat_q;
        prev_ta_d  = Ta;
        prev_tb_d  = Tb;
        lamp_a_d   = decode(La);
        lamp_b_d   = decode(Lb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            prev_pat_q <= P0;
            prev_ta_q  <= 1'b0;
            prev_tb_q  <= 1'b0;
            dwell_q    <= '0;
            lamp_a_q   <= '0;
            lamp_b_q   <= '0;
            phase_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
            err_cnt_q  <= '0;
            rounds_q   <= '0;
            starve_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_pat_q <= prev_pat_d;
            prev_ta_q  <= prev_ta_d;
            prev_tb_q  <= prev_tb_d;
            dwell_q    <= dwell_d;
            lamp_a_q   <= lamp_a_d;
            lamp_b_q   <= lamp_b_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
            rounds_q   <= rounds_d;
            starve_q   <= starve_d;
        end
    end

    assign lamp_a   = lamp_a_q;
    assign lamp_b   = lamp_b_q;
    assign phase    = phase_q;
    assign locked   = (state_q == LOCKED);
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_cnt  = err_cnt_q;
    assign rounds   = rounds_q;
    assign starve   = starve_q;

endmodule
